// File: rtl/pipe_pkg.sv
// pipe_pkg: shared defaults and stage indices for the pipeline controller
package pipe_pkg;
  localparam int NUM_STAGES_DEF = 5;
  localparam int XLEN_DEF       = 32;
  localparam int PC_STEP_DEF    = 4;
  localparam int STG_IF         = 0;
  localparam int STG_ID         = 1;
  localparam int STG_EX         = 2;
  localparam int STG_MEM        = 3;
  localparam int STG_WB         = 4;
endpackage

// File: rtl/pc_gen.sv
// pc_gen: fetch PC register with redirect/advance/hold next-PC mux
module pc_gen
  import pipe_pkg::*;
#(
  parameter int XLEN    = XLEN_DEF,
  parameter int PC_STEP = PC_STEP_DEF
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic [XLEN-1:0] boot_addr_i,
  input  logic            flush_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  input  logic            advance_i,
  output logic [XLEN-1:0] pc_o
);
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] w_pc_nxt;
  always_comb w_pc_nxt = flush_i ? redirect_pc_i : advance_i ? r_pc + XLEN'(PC_STEP) : r_pc;
  always_ff @(posedge clk_i) r_pc <= !rst_ni ? boot_addr_i : w_pc_nxt;
  assign pc_o = r_pc;
endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: in-order pipeline hold/flush/valid control with fetch PC and retire counter
module pipe_ctrl
  import pipe_pkg::*;
#(
  parameter int NUM_STAGES = NUM_STAGES_DEF,
  parameter int XLEN       = XLEN_DEF,
  parameter int PC_STEP    = PC_STEP_DEF,
  localparam int SW        = $clog2(NUM_STAGES)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [XLEN-1:0]       boot_addr_i,
  input  logic [NUM_STAGES-1:0] stall_req_i,
  input  logic                  flush_req_i,
  input  logic [SW-1:0]         flush_stage_i,
  input  logic [XLEN-1:0]       redirect_pc_i,
  input  logic                  fetch_ack_i,
  output logic                  fetch_req_o,
  output logic [XLEN-1:0]       fetch_pc_o,
  output logic [NUM_STAGES-1:0] stage_valid_o,
  output logic [NUM_STAGES-1:0] stage_en_o,
  output logic [NUM_STAGES-1:0] flush_o,
  output logic [63:0]           instret_o
);
  localparam int N = NUM_STAGES;
  logic [N-1:0]  r_valid;
  logic          r_started;
  logic [63:0]   r_instret;
  logic [N-1:0]  w_hold;
  logic [N-1:0]  w_flush;
  logic [N-1:0]  w_valid_nxt;
  logic [SW-1:0] w_fs;
  logic          w_fire;
  // a held stage only backs up its predecessor if it actually holds an instruction
  always_comb begin
    w_fs = (flush_stage_i > SW'(N-2)) ? SW'(N-2) : flush_stage_i;
    w_hold = '0;
    w_hold[N-1] = stall_req_i[N-1];
    for (int k = N-2; k >= 0; k--) w_hold[k] = stall_req_i[k] | (w_hold[k+1] & r_valid[k+1]);
    for (int k = 0; k < N; k++) w_flush[k] = flush_req_i & (SW'(k) <= w_fs);
  end
  assign fetch_req_o = r_started & !w_hold[STG_IF] & !flush_req_i;
  assign w_fire      = fetch_req_o & fetch_ack_i;
  // the stage just above a flushed one takes a bubble instead of the killed instruction
  always_comb begin
    w_valid_nxt = '0;
    w_valid_nxt[0] = w_flush[0] ? 1'b0 : w_hold[0] ? r_valid[0] : w_fire;
    for (int k = 1; k < N; k++)
      w_valid_nxt[k] = w_flush[k] ? 1'b0 : w_hold[k] ? r_valid[k] :
                       (r_valid[k-1] & !w_hold[k-1] & !w_flush[k-1]);
  end
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_valid   <= '0;
      r_started <= 1'b0;
      r_instret <= '0;
    end else begin
      r_valid   <= w_valid_nxt;
      r_started <= 1'b1;
      r_instret <= r_instret + 64'(r_valid[N-1] & !w_hold[N-1]);
    end
  end
  pc_gen #(.XLEN(XLEN), .PC_STEP(PC_STEP)) u_pc_gen (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .boot_addr_i  (boot_addr_i),
    .flush_i      (flush_req_i),
    .redirect_pc_i(redirect_pc_i),
    .advance_i    (w_fire),
    .pc_o         (fetch_pc_o)
  );
  assign stage_valid_o = r_valid;
  assign stage_en_o    = ~w_hold | w_flush;
  assign flush_o       = w_flush;
  assign instret_o     = r_instret;
endmodule
